if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 124 ++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a one-entry output register.
//
// Holds the program counter and presents it to instruction memory. The
// memory responds combinationally, and the returned word is captured into
// the id_* register together with its address. The id_* register only
// advances when it is empty or is consumed by decode in the same cycle, so a
// stalled decode never loses or repeats an instruction. A redirect
// (branch/jump) overrides everything else. It reloads the PC and flushes the
// id_* register, which leaves a single bubble.
//
// Parameters
//   RESET_PC        word-aligned PC loaded while reset is asserted
//   NOP_INSTR       value shown on id_instr whenever id_valid is 0
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   imem_addr  [31:0] out  byte address to instruction memory (= PC register)
//   imem_instr [31:0] in   instruction word for imem_addr (combinational)
//   fetch_en        in   1 = new fetches permitted
//   redirect_valid  in   one-cycle PC change request
//   redirect_pc [31:0] in  redirect target; low two bits are dropped
//   id_ready        in   decode accepts id_* this cycle
//   id_valid        out  id_pc/id_instr hold a fetched instruction
//   id_pc      [31:0] out  byte address of id_instr
//   id_instr   [31:0] out  fetched instruction
//   fetch_err       out  sticky: a misaligned redirect was seen
//   fetch_count [31:0] out  number of id_valid && id_ready handshakes
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_reg,          pc_next;
    logic        id_valid_reg,    id_valid_next;
    logic [31:0] id_pc_reg,       id_pc_next;
    logic [31:0] id_instr_reg,    id_instr_next;
    logic        fetch_err_reg,   fetch_err_next;
    logic [31:0] fetch_count_reg, fetch_count_next;

    logic fire;
    logic load;

    // The output register can take a new word when it is empty or is being
    // drained this cycle. A redirect suppresses the load because the word
    // currently on imem_instr belongs to the abandoned path.
    assign fire = id_valid_reg && id_ready;
    assign load = (!id_valid_reg || id_ready) && fetch_en && !redirect_valid;

    always_comb begin
        pc_next          = pc_reg;
        id_valid_next    = id_valid_reg;
        id_pc_next       = id_pc_reg;
        id_instr_next    = id_instr_reg;
        fetch_err_next   = fetch_err_reg;
        // Counts every handshake, including one that coincides with a
        // redirect: the consumer did take that instruction.
        fetch_count_next = fire ? fetch_count_reg + 32'd1 : fetch_count_reg;

        if (redirect_valid) begin
            pc_next       = {redirect_pc[31:2], 2'b00};
            id_valid_next = 1'b0;
            id_instr_next = NOP_INSTR;
            if (redirect_pc[1:0] != 2'b00) begin
                fetch_err_next = 1'b1;
            end
        end else if (load) begin
            id_instr_next = imem_instr;
            id_pc_next    = pc_reg;
            id_valid_next = 1'b1;
            // Natural 32-bit wrap: 0xFFFFFFFC + 4 = 0x00000000.
            pc_next       = pc_reg + 32'd4;
        end else if (fire) begin
            // Consumed while fetching is disabled: the register empties and
            // the PC stays put so fetching later resumes where it stopped.
            id_valid_next = 1'b0;
            id_instr_next = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            id_valid_reg    <= 1'b0;
            id_pc_reg       <= 32'h0000_0000;
            id_instr_reg    <= NOP_INSTR;
            fetch_err_reg   <= 1'b0;
            fetch_count_reg <= 32'h0000_0000;
        end else begin
            pc_reg          <= pc_next;
            id_valid_reg    <= id_valid_next;
            id_pc_reg       <= id_pc_next;
            id_instr_reg    <= id_instr_next;
            fetch_err_reg   <= fetch_err_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    // imem_addr comes straight from the PC register. Because of this, no
    // control input has a combinational path to the memory address.
    assign imem_addr   = pc_reg;
    assign id_valid    = id_valid_reg;
    assign id_pc       = id_pc_reg;
    assign id_instr    = id_instr_reg;
    assign fetch_err   = fetch_err_reg;
    assign fetch_count = fetch_count_reg;

endmodule
